// File: rtl/spt_autobuf.sv
`default_nettype none
// ============================================================================
// Module   : spt_autobuf
// Purpose  : Serial-port autobuffer address generator. There are two
//            independent channels, RX and TX. Each one keeps a circular or
//            linear data-memory index. It raises a service request to the
//            arbiter on each receive-full or transmit-empty event, and it
//            advances the index when the arbiter acknowledges.
// Ports    : DSPCLK   - system clock, rising edge
//            RST      - asynchronous active-high reset
//            DMD_di   - register write data ([13:0] addresses, [1:0] CTL,
//                       [15] ROVF clear on a CTL write)
//            REG_WE   - one-cycle register write strobe
//            REG_SEL  - 0 RBASE 1 RMOD 2 RLEN 3 TBASE 4 TMOD 5 TLEN 6 CTL
//            RXFULL   - receive-word-ready pulse
//            TXEMPTY  - transmit-buffer-empty pulse
//            R0Sack   - RX acknowledge from the arbiter
//            T0Sack   - TX acknowledge from the arbiter
//            R0Sreqi  - RX service request
//            T0Sreqi  - TX service request
//            RADDR    - current RX index
//            TADDR    - current TX index
//            ROVF     - sticky RX overrun flag (only when SPT_ABUF_OVF_EN)
// Config   : SPT_ABUF_OVF_EN - adds the ROVF port and its overrun logic
// Revision : 1.0 - initial release
// ============================================================================
module spt_autobuf (
    input  logic        DSPCLK,
    input  logic        RST,
    input  logic [15:0] DMD_di,
    input  logic        REG_WE,
    input  logic [2:0]  REG_SEL,
    input  logic        RXFULL,
    input  logic        TXEMPTY,
    input  logic        R0Sack,
    input  logic        T0Sack,
    output logic        R0Sreqi,
    output logic        T0Sreqi,
    output logic [13:0] RADDR,
`ifdef SPT_ABUF_OVF_EN
    output logic [13:0] TADDR,
    output logic        ROVF
`else
    output logic [13:0] TADDR
`endif
);

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    localparam logic [2:0] SEL_RBASE = 3'd0;
    localparam logic [2:0] SEL_RMOD  = 3'd1;
    localparam logic [2:0] SEL_RLEN  = 3'd2;
    localparam logic [2:0] SEL_TBASE = 3'd3;
    localparam logic [2:0] SEL_TMOD  = 3'd4;
    localparam logic [2:0] SEL_TLEN  = 3'd5;
    localparam logic [2:0] SEL_CTL   = 3'd6;

    logic [13:0] rbase_q, rbase_d, rmod_q, rmod_d, rlen_q, rlen_d, ridx_q, ridx_d;
    logic [13:0] tbase_q, tbase_d, tmod_q, tmod_d, tlen_q, tlen_d, tidx_q, tidx_d;
    logic [1:0]  ctl_q, ctl_d;
    state_t      rstate_q, rstate_d, tstate_q, tstate_d;
    logic        rovf_q, rovf_d;
    logic        unused_di;

    // Bit 14 is never used. Bit 15 is used only by the overrun clear.
    assign unused_di = &{1'b0, DMD_di[15:14]};

    // Next index: INDEX + sign-extended MOD in 15 bits, then an unsigned
    // 15-bit wrap into [BASE, BASE+LEN). When LEN is 0 the next index is
    // truncated modulo 2^14 instead, which gives linear addressing.
    function automatic logic [13:0] next_index(input logic [13:0] idx,
                                               input logic [13:0] base,
                                               input logic [13:0] modv,
                                               input logic [13:0] len);
        logic [14:0] nxt;
        logic [14:0] lim;
        nxt = {1'b0, idx} + {modv[13], modv};
        lim = {1'b0, base} + {1'b0, len};
        if (len != 14'd0) begin
            if (nxt >= lim) begin
                nxt = nxt - {1'b0, len};
            end else if (nxt < {1'b0, base}) begin
                nxt = nxt + {1'b0, len};
            end
        end
        return nxt[13:0];
    endfunction

    always_comb begin
        rbase_d  = rbase_q;
        rmod_d   = rmod_q;
        rlen_d   = rlen_q;
        ridx_d   = ridx_q;
        tbase_d  = tbase_q;
        tmod_d   = tmod_q;
        tlen_d   = tlen_q;
        tidx_d   = tidx_q;
        ctl_d    = ctl_q;
        rstate_d = rstate_q;
        tstate_d = tstate_q;
        rovf_d   = rovf_q;

        // RX channel. An ack advances the index only while AUTO is still
        // set. Clearing AUTO abandons the request with the index untouched.
        case (rstate_q)
            ST_IDLE: if (ctl_q[0] && RXFULL) rstate_d = ST_REQ;
            ST_REQ: begin
                if (!ctl_q[0]) begin
                    rstate_d = ST_IDLE;
                end else if (R0Sack) begin
                    ridx_d = next_index(ridx_q, rbase_q, rmod_q, rlen_q);
                    // A new event on the same edge re-arms the request.
                    rstate_d = RXFULL ? ST_REQ : ST_IDLE;
                end
            end
            default: rstate_d = ST_IDLE;
        endcase

        // TX channel mirrors RX.
        case (tstate_q)
            ST_IDLE: if (ctl_q[1] && TXEMPTY) tstate_d = ST_REQ;
            ST_REQ: begin
                if (!ctl_q[1]) begin
                    tstate_d = ST_IDLE;
                end else if (T0Sack) begin
                    tidx_d = next_index(tidx_q, tbase_q, tmod_q, tlen_q);
                    tstate_d = TXEMPTY ? ST_REQ : ST_IDLE;
                end
            end
            default: tstate_d = ST_IDLE;
        endcase

        // Register writes come after the ack update so that a BASE write
        // overrides an index advance on the same edge.
        if (REG_WE) begin
            case (REG_SEL)
                SEL_RBASE: begin rbase_d = DMD_di[13:0]; ridx_d = DMD_di[13:0]; end
                SEL_RMOD:  rmod_d = DMD_di[13:0];
                SEL_RLEN:  rlen_d = DMD_di[13:0];
                SEL_TBASE: begin tbase_d = DMD_di[13:0]; tidx_d = DMD_di[13:0]; end
                SEL_TMOD:  tmod_d = DMD_di[13:0];
                SEL_TLEN:  tlen_d = DMD_di[13:0];
                SEL_CTL:   ctl_d  = DMD_di[1:0];
                default: ;
            endcase
        end

`ifdef SPT_ABUF_OVF_EN
        // An overrun is an RX event that is dropped because a request is
        // still pending. The set is applied after the clear, so a set wins
        // when both happen in the same cycle.
        if (REG_WE && (REG_SEL == SEL_CTL) && DMD_di[15]) rovf_d = 1'b0;
        if ((rstate_q == ST_REQ) && ctl_q[0] && RXFULL && !R0Sack) rovf_d = 1'b1;
`else
        rovf_d = 1'b0;
`endif
    end

    always_ff @(posedge DSPCLK or posedge RST) begin
        if (RST) begin
            rbase_q  <= '0;
            rmod_q   <= '0;
            rlen_q   <= '0;
            ridx_q   <= '0;
            tbase_q  <= '0;
            tmod_q   <= '0;
            tlen_q   <= '0;
            tidx_q   <= '0;
            ctl_q    <= '0;
            rstate_q <= ST_IDLE;
            tstate_q <= ST_IDLE;
            rovf_q   <= 1'b0;
        end else begin
            rbase_q  <= rbase_d;
            rmod_q   <= rmod_d;
            rlen_q   <= rlen_d;
            ridx_q   <= ridx_d;
            tbase_q  <= tbase_d;
            tmod_q   <= tmod_d;
            tlen_q   <= tlen_d;
            tidx_q   <= tidx_d;
            ctl_q    <= ctl_d;
            rstate_q <= rstate_d;
            tstate_q <= tstate_d;
            rovf_q   <= rovf_d;
        end
    end

    assign R0Sreqi = (rstate_q == ST_REQ);
    assign T0Sreqi = (tstate_q == ST_REQ);
    assign RADDR   = ridx_q;
    assign TADDR   = tidx_q;
`ifdef SPT_ABUF_OVF_EN
    assign ROVF    = rovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = rovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spt_autobuf.sv
`default_nettype none
// ============================================================================
// Module   : tb_spt_autobuf
// Purpose  : Directed self-checking bench for spt_autobuf. The expected
//            index is pushed to a queue when an event is driven. It is popped
//            and compared when the request appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spt_autobuf;

    logic        DSPCLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] DMD_di = '0;
    logic        REG_WE = 1'b0;
    logic [2:0]  REG_SEL = '0;
    logic        RXFULL = 1'b0, TXEMPTY = 1'b0, R0Sack = 1'b0, T0Sack = 1'b0;
    logic        R0Sreqi, T0Sreqi;
    logic [13:0] RADDR, TADDR;
`ifdef SPT_ABUF_OVF_EN
    logic        ROVF;
`endif

    int checks = 0;
    int errors = 0;

    int m_rbase = 0, m_rmod = 0, m_rlen = 0, m_ridx = 0;
    int m_tbase = 0, m_tmod = 0, m_tlen = 0, m_tidx = 0;
    int q_r[$];
    int q_t[$];

    spt_autobuf dut (
        .DSPCLK (DSPCLK),
        .RST    (RST),
        .DMD_di (DMD_di),
        .REG_WE (REG_WE),
        .REG_SEL(REG_SEL),
        .RXFULL (RXFULL),
        .TXEMPTY(TXEMPTY),
        .R0Sack (R0Sack),
        .T0Sack (T0Sack),
        .R0Sreqi(R0Sreqi),
        .T0Sreqi(T0Sreqi),
        .RADDR  (RADDR),
`ifdef SPT_ABUF_OVF_EN
        .TADDR  (TADDR),
        .ROVF   (ROVF)
`else
        .TADDR  (TADDR)
`endif
    );

    always #5 DSPCLK = ~DSPCLK;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge DSPCLK);
        #1;
    endtask

    // Reference index step: signed offset inside the ring, or linear mod 2^14.
    function automatic int model_next(input int idx, input int base, input int modr, input int len);
        int m;
        int off;
        m = (modr >= 'h2000) ? modr - 'h4000 : modr;
        if (len == 0) return (idx + m) & 'h3FFF;
        off = idx - base + m;
        off = ((off % len) + len) % len;
        return base + off;
    endfunction

    task automatic wr(input int sel, input int data);
        REG_SEL = sel[2:0];
        DMD_di  = data[15:0];
        REG_WE  = 1'b1;
        tick();
        REG_WE  = 1'b0;
        case (sel)
            0: begin m_rbase = data & 'h3FFF; m_ridx = m_rbase; end
            1: m_rmod = data & 'h3FFF;
            2: m_rlen = data & 'h3FFF;
            3: begin m_tbase = data & 'h3FFF; m_tidx = m_tbase; end
            4: m_tmod = data & 'h3FFF;
            5: m_tlen = data & 'h3FFF;
            default: ;
        endcase
    endtask

    task automatic r_event();
        q_r.push_back(m_ridx);
        RXFULL = 1'b1;
        tick();
        RXFULL = 1'b0;
    endtask

    task automatic t_event();
        q_t.push_back(m_tidx);
        TXEMPTY = 1'b1;
        tick();
        TXEMPTY = 1'b0;
    endtask

    task automatic r_expect(input string tag);
        int n = 0;
        while (!R0Sreqi && n < 4) begin tick(); n++; end
        chk({tag, "_rreq"}, int'(R0Sreqi), 1);
        if (q_r.size() > 0) chk({tag, "_raddr"}, int'(RADDR), q_r.pop_front());
        else chk({tag, "_rqueue"}, 0, 1);
    endtask

    task automatic t_expect(input string tag);
        int n = 0;
        while (!T0Sreqi && n < 4) begin tick(); n++; end
        chk({tag, "_treq"}, int'(T0Sreqi), 1);
        if (q_t.size() > 0) chk({tag, "_taddr"}, int'(TADDR), q_t.pop_front());
        else chk({tag, "_tqueue"}, 0, 1);
    endtask

    task automatic r_ack();
        R0Sack = 1'b1;
        tick();
        R0Sack = 1'b0;
        m_ridx = model_next(m_ridx, m_rbase, m_rmod, m_rlen);
        chk("r_ack_drop", int'(R0Sreqi), 0);
    endtask

    task automatic t_ack();
        T0Sack = 1'b1;
        tick();
        T0Sack = 1'b0;
        m_tidx = model_next(m_tidx, m_tbase, m_tmod, m_tlen);
        chk("t_ack_drop", int'(T0Sreqi), 0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_rreq", int'(R0Sreqi), 0);
        chk("rst_treq", int'(T0Sreqi), 0);
        chk("rst_raddr", int'(RADDR), 0);
        chk("rst_taddr", int'(TADDR), 0);
`ifdef SPT_ABUF_OVF_EN
        chk("rst_rovf", int'(ROVF), 0);
`endif
        RST = 1'b0;
        tick();

        // Circular RX ring of 4, step +1
        wr(0, 'h100);
        wr(2, 4);
        wr(1, 1);
        wr(6, 3);
        for (int i = 0; i < 5; i++) begin
            r_event();
            r_expect("ring");
            r_ack();
        end

        // Negative modifier wraps below BASE
        wr(0, 'h100);
        wr(1, 'h3FFF);
        r_event();
        r_expect("neg0");
        r_ack();
        r_event();
        r_expect("neg1");
        chk("neg_value", int'(RADDR), 'h103);
        r_ack();

        // Linear TX addressing wraps modulo 2^14
        wr(3, 'h3FFE);
        wr(5, 0);
        wr(4, 3);
        t_event();
        t_expect("lin0");
        t_ack();
        t_event();
        t_expect("lin1");
        chk("lin_value", int'(TADDR), 1);

        // Event together with ack keeps the request high; a lone event is dropped
        wr(1, 1);
        r_event();
        r_expect("evack");
        RXFULL = 1'b1;
        R0Sack = 1'b1;
        tick();
        RXFULL = 1'b0;
        R0Sack = 1'b0;
        m_ridx = model_next(m_ridx, m_rbase, m_rmod, m_rlen);
        chk("evack_req", int'(R0Sreqi), 1);
        chk("evack_addr", int'(RADDR), m_ridx);
        RXFULL = 1'b1;
        tick();
        RXFULL = 1'b0;
        chk("ovr_req", int'(R0Sreqi), 1);
        chk("ovr_addr", int'(RADDR), m_ridx);
`ifdef SPT_ABUF_OVF_EN
        chk("ovr_rovf", int'(ROVF), 1);
        wr(6, 'h8003);
        chk("ovr_clear", int'(ROVF), 0);
`endif
        r_ack();
        chk("ovr_wrap", int'(RADDR), 'h100);

        // Ack in IDLE is ignored
        R0Sack = 1'b1;
        tick();
        R0Sack = 1'b0;
        chk("idle_ack_req", int'(R0Sreqi), 0);
        chk("idle_ack_addr", int'(RADDR), m_ridx);

        // Events ignored while RAUTO = 0
        wr(6, 2);
        RXFULL = 1'b1;
        tick();
        RXFULL = 1'b0;
        tick();
        chk("noauto_req", int'(R0Sreqi), 0);

        // Clearing TAUTO while the TX request is pending abandons it
        chk("tauto_pre", int'(T0Sreqi), 1);
        wr(6, 0);
        tick();
        chk("tauto_req", int'(T0Sreqi), 0);
        chk("tauto_addr", int'(TADDR), 1);

        // A BASE write beats an ack on the same edge
        wr(6, 3);
        r_event();
        r_expect("basepri");
        REG_SEL = 3'd0;
        DMD_di  = 16'h0200;
        REG_WE  = 1'b1;
        R0Sack  = 1'b1;
        tick();
        REG_WE  = 1'b0;
        R0Sack  = 1'b0;
        m_rbase = 'h200;
        m_ridx  = 'h200;
        chk("basepri_addr", int'(RADDR), 'h200);
        chk("basepri_req", int'(R0Sreqi), 0);

        // Asynchronous reset during active requests
        r_event();
        r_expect("arst");
        t_event();
        t_expect("arst");
        #2;
        RST = 1'b1;
        #1;
        chk("arst_rreq", int'(R0Sreqi), 0);
        chk("arst_treq", int'(T0Sreqi), 0);
        chk("arst_raddr", int'(RADDR), 0);
        chk("arst_taddr", int'(TADDR), 0);
        R0Sack = 1'b1;
        T0Sack = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        R0Sack = 1'b0;
        T0Sack = 1'b0;
        chk("post_rst_rreq", int'(R0Sreqi), 0);
        chk("post_rst_raddr", int'(RADDR), 0);
        chk("post_rst_taddr", int'(TADDR), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
